ad5662_spi_rx: RTL

- Receive-side decoder for the AD5662 3-wire serial DAC interface (sclk, mosi, sync_n), the same interface the reference PLL uses to steer the VCTCXO trim DAC.
- Oversamples the three lines in the system clock domain, frames 24-bit words and extracts the power-down mode and the 16-bit DAC code.
- Used as a loopback monitor of the trim DAC value for status/telemetry, and as a bit-accurate DAC model in benches.

---
 rtl/ad5662_spi_rx.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ad5662_spi_rx.sv
// Receive-side decoder for the AD5662 3-wire DAC interface: oversamples sclk/mosi/sync_n
// in the clk domain, frames 24-bit words and reports the DAC code and power-down bits.
module ad5662_spi_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FRAME_BITS     = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        sync_n,
  output logic [15:0] dac_code,
  output logic [1:0]  pd_mode,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [1:0]  err_cause,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int         TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, sync_sync;
  logic                   sclk_d, sync_d;
  logic                   sclk_s, mosi_s, sync_s;
  logic                   sclk_fall, sync_fall, sync_rise;

  logic [1:0]    state;
  logic [4:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  // Only DB17:0 matter; the 17 oldest-needed bits plus the live mosi bit form the word.
  logic [16:0]   shift_reg;
  logic [17:0]   word_next;

  // Resetting to 0 means a line held low across reset never yields a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      sync_sync <= '0;
      sclk_d    <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sync_sync <= {sync_sync[SYNC_STAGES-2:0], sync_n};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      sync_d    <= sync_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sync_s    = sync_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign sync_fall = sync_d & ~sync_s;
  assign sync_rise = ~sync_d & sync_s;
  assign word_next = {shift_reg, mosi_s};

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      shift_reg   <= '0;
      dac_code    <= '0;
      pd_mode     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_cause   <= '0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_fall) begin
            state   <= SHIFT;
            bit_cnt <= '0;
            to_cnt  <= '0;
          end
        end
        SHIFT: begin
          // A sync_n rise wins over a coincident sclk fall, which is then not counted.
          if (sync_rise) begin
            state <= IDLE;
            if (bit_cnt != '0) begin
              frame_err <= 1'b1;
              err_cause <= 2'b01;
            end
          end else if (sclk_fall) begin
            shift_reg <= word_next[16:0];
            bit_cnt   <= bit_cnt + 5'd1;
            to_cnt    <= '0;
            if (bit_cnt == LAST_BIT) begin
              dac_code    <= word_next[15:0];
              pd_mode     <= word_next[17:16];
              frame_valid <= 1'b1;
              frame_cnt   <= frame_cnt + 16'd1;
              state       <= HOLD;
            end
          end else if (to_cnt == TO_LAST) begin
            frame_err <= 1'b1;
            err_cause <= 2'b10;
            state     <= HOLD;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (sync_rise) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
